reg_write_scoreboard: RTL and testbench

//  Producer-side register-write tracker. It complements the bypass mux selection in EX: operand forwarding covers

---
 rtl/reg_write_scoreboard.sv | 68 ++++++
 tb/tb_reg_write_scoreboard.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_scoreboard.sv
// reg_write_scoreboard: per-register outstanding-write counters that stall issue on RAW or counter-full hazards; ports are issue_*, wb_*, kill_* in and stall/issue_accept/busy_vec/pending_total/err_underflow out
module reg_write_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2,
    parameter int TOT_W    = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issue_valid,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rs1,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rs2,
    input  logic                        issue_use_rs1,
    input  logic                        issue_use_rs2,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
    input  logic                        issue_reg_write,
    input  logic                        wb_valid,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd,
    input  logic                        kill_valid,
    input  logic [$clog2(NUM_REGS)-1:0] kill_rd,
    output logic                        stall,
    output logic                        issue_accept,
    output logic [NUM_REGS-1:0]         busy_vec,
    output logic [TOT_W-1:0]            pending_total,
    output logic                        err_underflow
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int XW = CNT_W + 2;
    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [CNT_W-1:0] nxt [NUM_REGS];
    logic [XW-1:0] cx [NUM_REGS];
    logic [XW-1:0] rx [NUM_REGS];
    logic [NUM_REGS-1:0] under, inc, busy_n;
    logic [TOT_W-1:0] tot_n;
    logic busy1, busy2, full;
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign cx[i] = XW'(cnt[i]);
        assign rx[i] = (i == 0) ? '0 : XW'(wb_valid && wb_rd == AW'(i)) + XW'(kill_valid && kill_rd == AW'(i));
        assign under[i] = rx[i] > cx[i];
        assign inc[i] = issue_accept && issue_reg_write && issue_rd == AW'(i) && i != 0;
        assign nxt[i] = CNT_W'(cx[i] - (under[i] ? cx[i] : rx[i]) + XW'(inc[i]));
    end
    assign busy1 = issue_use_rs1 && issue_rs1 != '0 && cx[issue_rs1] > rx[issue_rs1];
    assign busy2 = issue_use_rs2 && issue_rs2 != '0 && cx[issue_rs2] > rx[issue_rs2];
    assign full = issue_reg_write && issue_rd != '0 && cx[issue_rd] == XW'(2 ** CNT_W - 1) + rx[issue_rd];
    assign stall = issue_valid && (busy1 || busy2 || full);
    assign issue_accept = issue_valid && !stall;
    always_comb begin
        tot_n = '0;
        busy_n = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            tot_n = tot_n + TOT_W'(nxt[k]);
            busy_n[k] = |nxt[k];
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '{default: '0};
            busy_vec <= '0;
            pending_total <= '0;
            err_underflow <= 1'b0;
        end else begin
            cnt <= nxt;
            busy_vec <= busy_n;
            pending_total <= tot_n;
            err_underflow <= err_underflow || |under;
        end
    end
endmodule

// File: tb/tb_reg_write_scoreboard.sv
// tb_reg_write_scoreboard: directed scenarios plus randomized traffic checked against a counting model
module tb_reg_write_scoreboard;
    logic clk = 1'b0, reset = 1'b0;
    logic issue_valid, issue_use_rs1, issue_use_rs2, issue_reg_write, wb_valid, kill_valid;
    logic [4:0] issue_rs1, issue_rs2, issue_rd, wb_rd, kill_rd;
    logic stall, issue_accept, err_underflow;
    logic [31:0] busy_vec;
    logic [6:0] pending_total;
    int vectors = 0, miscompares = 0;
    int m_cnt [32];
    bit m_err;

    reg_write_scoreboard dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2), .issue_rd(issue_rd),
        .issue_reg_write(issue_reg_write), .wb_valid(wb_valid), .wb_rd(wb_rd), .kill_valid(kill_valid),
        .kill_rd(kill_rd), .stall(stall), .issue_accept(issue_accept), .busy_vec(busy_vec),
        .pending_total(pending_total), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic idle();
        issue_valid = 0; issue_use_rs1 = 0; issue_use_rs2 = 0; issue_reg_write = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        wb_valid = 0; wb_rd = 0; kill_valid = 0; kill_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_rd(input logic [4:0] rd);
        idle();
        issue_valid = 1; issue_reg_write = 1; issue_rd = rd;
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        tick();
        reset = 1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (busy_vec !== 32'd0) begin miscompares++; $display("FAIL reset_busy got %h want 0", busy_vec); end
        vectors++; if (pending_total !== 7'd0) begin miscompares++; $display("FAIL reset_total got %0d want 0", pending_total); end
        write_rd(3);
        write_rd(3);
        wb_valid = 1; wb_rd = 4;
        tick();
        idle();
        vectors++; if (pending_total !== 7'd2 || err_underflow !== 1'b1) begin miscompares++; $display("FAIL pre_reset got total=%0d err=%b want 2/1", pending_total, err_underflow); end
        #2 reset = 0;
        #1;
        vectors++; if (busy_vec !== 32'd0 || pending_total !== 7'd0 || err_underflow !== 1'b0) begin
            miscompares++; $display("FAIL async_reset got busy=%h total=%0d err=%b want 0/0/0", busy_vec, pending_total, err_underflow);
        end
        tick();
        reset = 1;
        #1;
    endtask

    task automatic test_raw_stall();
        do_reset();
        write_rd(5);
        vectors++; if (busy_vec[5] !== 1'b1) begin miscompares++; $display("FAIL raw_busy5 got %b want 1", busy_vec[5]); end
        issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 5; issue_reg_write = 1; issue_rd = 6;
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++; if (stall !== 1'b1 || issue_accept !== 1'b0) begin miscompares++; $display("FAIL raw_stall cyc%0d got stall=%b acc=%b want 1/0", c, stall, issue_accept); end
            tick();
        end
        wb_valid = 1; wb_rd = 5;
        #1;
        vectors++; if (stall !== 1'b0 || issue_accept !== 1'b1) begin miscompares++; $display("FAIL raw_release got stall=%b acc=%b want 0/1", stall, issue_accept); end
        tick();
        idle();
        vectors++; if (busy_vec[5] !== 1'b0 || busy_vec[6] !== 1'b1 || pending_total !== 7'd1) begin
            miscompares++; $display("FAIL raw_after got b5=%b b6=%b total=%0d want 0/1/1", busy_vec[5], busy_vec[6], pending_total);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 3; k++) write_rd(7);
        vectors++; if (pending_total !== 7'd3) begin miscompares++; $display("FAIL full_total got %0d want 3", pending_total); end
        issue_valid = 1; issue_reg_write = 1; issue_rd = 7;
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL full_stall got %b want 1", stall); end
        wb_valid = 1; wb_rd = 7;
        #1;
        vectors++; if (stall !== 1'b0 || issue_accept !== 1'b1) begin miscompares++; $display("FAIL full_release got stall=%b acc=%b want 0/1", stall, issue_accept); end
        tick();
        idle();
        vectors++; if (pending_total !== 7'd3 || busy_vec[7] !== 1'b1 || err_underflow !== 1'b0) begin
            miscompares++; $display("FAIL full_after got total=%0d b7=%b err=%b want 3/1/0", pending_total, busy_vec[7], err_underflow);
        end
    endtask

    task automatic test_dual_release();
        do_reset();
        write_rd(9);
        write_rd(9);
        vectors++; if (pending_total !== 7'd2) begin miscompares++; $display("FAIL dual_pre got %0d want 2", pending_total); end
        wb_valid = 1; wb_rd = 9; kill_valid = 1; kill_rd = 9;
        tick();
        idle();
        vectors++; if (pending_total !== 7'd0 || busy_vec[9] !== 1'b0 || err_underflow !== 1'b0) begin
            miscompares++; $display("FAIL dual_after got total=%0d b9=%b err=%b want 0/0/0", pending_total, busy_vec[9], err_underflow);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        wb_valid = 1; wb_rd = 4;
        tick();
        idle();
        vectors++; if (err_underflow !== 1'b1 || pending_total !== 7'd0) begin miscompares++; $display("FAIL underflow got err=%b total=%0d want 1/0", err_underflow, pending_total); end
        for (int k = 0; k < 3; k++) tick();
        vectors++; if (err_underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_sticky got %b want 1", err_underflow); end
    endtask

    task automatic test_x0();
        do_reset();
        write_rd(2);
        issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 0; issue_use_rs2 = 1; issue_rs2 = 0;
        issue_reg_write = 1; issue_rd = 0; wb_valid = 1; wb_rd = 0;
        #1;
        vectors++; if (stall !== 1'b0 || issue_accept !== 1'b1) begin miscompares++; $display("FAIL x0_stall got stall=%b acc=%b want 0/1", stall, issue_accept); end
        tick();
        idle();
        vectors++; if (pending_total !== 7'd1 || busy_vec !== 32'h4 || err_underflow !== 1'b0) begin
            miscompares++; $display("FAIL x0_after got total=%0d busy=%h err=%b want 1/4/0", pending_total, busy_vec, err_underflow);
        end
    endtask

    function automatic int relf(input int r);
        if (r == 0) return 0;
        return int'(wb_valid && wb_rd == r) + int'(kill_valid && kill_rd == r);
    endfunction

    task automatic test_random();
        bit ex_stall, ex_acc;
        logic [31:0] ex_busy;
        int ex_tot, rl;
        do_reset();
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_err = 0;
        for (int n = 0; n < 1500; n++) begin
            idle();
            issue_valid = $urandom_range(0, 3) != 0;
            issue_use_rs1 = $urandom_range(0, 1); issue_rs1 = $urandom_range(0, 7);
            issue_use_rs2 = $urandom_range(0, 1); issue_rs2 = $urandom_range(0, 7);
            issue_reg_write = $urandom_range(0, 3) != 0; issue_rd = $urandom_range(0, 7);
            wb_rd = $urandom_range(0, 7);
            wb_valid = $urandom_range(0, 2) == 0 && (m_cnt[wb_rd] != 0 || $urandom_range(0, 40) == 0);
            kill_rd = $urandom_range(0, 7);
            kill_valid = $urandom_range(0, 5) == 0 && (m_cnt[kill_rd] != 0 || $urandom_range(0, 40) == 0);
            ex_stall = issue_valid && ((issue_use_rs1 && issue_rs1 != 0 && m_cnt[issue_rs1] > relf(issue_rs1)) ||
                                       (issue_use_rs2 && issue_rs2 != 0 && m_cnt[issue_rs2] > relf(issue_rs2)) ||
                                       (issue_reg_write && issue_rd != 0 && m_cnt[issue_rd] - relf(issue_rd) == 3));
            ex_acc = issue_valid && !ex_stall;
            #1;
            vectors++; if (stall !== ex_stall || issue_accept !== ex_acc) begin
                miscompares++; $display("FAIL rnd_stall n=%0d got stall=%b acc=%b want %b/%b", n, stall, issue_accept, ex_stall, ex_acc);
            end
            ex_busy = '0;
            ex_tot = 0;
            for (int r = 1; r < 32; r++) begin
                rl = relf(r);
                if (rl > m_cnt[r]) begin m_err = 1; m_cnt[r] = 0; end else m_cnt[r] -= rl;
                if (ex_acc && issue_reg_write && issue_rd == r) m_cnt[r]++;
                ex_busy[r] = m_cnt[r] != 0;
                ex_tot += m_cnt[r];
            end
            tick();
            vectors++; if (busy_vec !== ex_busy || pending_total !== 7'(ex_tot) || err_underflow !== m_err) begin
                miscompares++; $display("FAIL rnd_state n=%0d got busy=%h total=%0d err=%b want %h/%0d/%b", n, busy_vec, pending_total, err_underflow, ex_busy, ex_tot, m_err);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_raw_stall();
        test_full();
        test_dual_release();
        test_underflow();
        test_x0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
